// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM state encoding, iteration count and sign-magnitude helper.
// The instruction decoder imports the same op constants.
package muldiv_pkg;

    localparam int unsigned MD_W       = 32;
    localparam int unsigned MD_OP_W    = 3;
    localparam int unsigned MD_ITERS   = 32;
    localparam int unsigned MD_CNT_W   = $clog2(MD_ITERS);
    localparam logic [MD_CNT_W-1:0] MD_LAST_STEP = MD_CNT_W'(MD_ITERS - 1);

    typedef enum logic [MD_OP_W-1:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101,
        MD_NOP6  = 3'b110,
        MD_NOP7  = 3'b111
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } md_mode_e;

    // Two's-complement negate when neg is set; |0x80000000| stays 0x80000000.
    function automatic logic [MD_W-1:0] md_abs(input logic [MD_W-1:0] v, input logic neg);
        return neg ? MD_W'((~v) + MD_W'(1)) : v;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between the execute stage and the mul/div unit.
//   master: pipeline side, drives start/op/a/b, observes busy/done/hi/lo.
//   slave : muldiv side.
interface muldiv_if;
    import muldiv_pkg::*;

    logic                  start;
    logic [MD_OP_W-1:0]    op;
    logic [MD_W-1:0]       a;
    logic [MD_W-1:0]       b;
    logic                  busy;
    logic                  done;
    logic [MD_W-1:0]       hi;
    logic [MD_W-1:0]       lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the mul/div datapath (combinational).
//   acc      : 64-bit accumulator {upper, lower}
//   operand  : multiplicand (mul) or divisor (div) magnitude
//   mode     : STEP_MUL shift-add, STEP_DIV restoring shift-subtract
//   acc_next : accumulator after this step
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic [2*MD_W-1:0] acc,
    input  logic [MD_W-1:0]   operand,
    input  md_mode_e          mode,
    output logic [2*MD_W-1:0] acc_next
);

    logic [MD_W:0] sum;
    logic [MD_W:0] diff;

    always_comb begin
        // Multiply: lower half holds the remaining multiplier bits, LSB first.
        sum  = {1'b0, acc[2*MD_W-1:MD_W]} + (acc[0] ? {1'b0, operand} : '0);
        // Divide: trial subtract of the divisor from the left-shifted remainder.
        diff = acc[2*MD_W-1:MD_W-1] - {1'b0, operand};
        acc_next = {sum, acc[MD_W-1:1]};
        if (mode == STEP_DIV) begin
            if (!diff[MD_W]) begin
                acc_next = {diff[MD_W-1:0], acc[MD_W-2:0], 1'b1};
            end else begin
                acc_next = {acc[2*MD_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv.sv
// Iterative 32-cycle multiply/divide unit holding architectural HI/LO.
//   clk, rst : clock, synchronous active-high reset
//   bus      : muldiv_if.slave (start/op/a/b in; busy/done/hi/lo out)
// Sign conditioning, step counter, FSM and HI/LO live here; the per-cycle
// datapath is muldiv_step.
module muldiv
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    md_state_e               state_q, state_d;
    logic [MD_CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]      acc_q, acc_d;
    logic [WIDTH-1:0]        opnd_q, opnd_d;
    md_mode_e                mode_q, mode_d;
    logic                    neg_res_q, neg_res_d;
    logic                    neg_rem_q, neg_rem_d;
    logic                    div0_q, div0_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [WIDTH-1:0]        hi_q, hi_d;
    logic [WIDTH-1:0]        lo_q, lo_d;

    md_op_e                  op;
    logic                    signed_op;
    logic                    sgn_a, sgn_b;
    logic [WIDTH-1:0]        mag_a, mag_b;
    logic [2*WIDTH-1:0]      step_acc;
    logic [2*WIDTH-1:0]      prod;
    logic [WIDTH-1:0]        quo_fix, rem_fix;
    logic [WIDTH-1:0]        res_hi, res_lo;

    muldiv_step u_step (
        .acc      (acc_q),
        .operand  (opnd_q),
        .mode     (mode_q),
        .acc_next (step_acc)
    );

    // Issue-side sign conditioning: magnitudes plus sign flags.
    always_comb begin
        op        = md_op_e'(bus.op);
        signed_op = (op == MD_MULT) || (op == MD_DIV);
        sgn_a     = signed_op & bus.a[WIDTH-1];
        sgn_b     = signed_op & bus.b[WIDTH-1];
        mag_a     = md_abs(bus.a, sgn_a);
        mag_b     = md_abs(bus.b, sgn_b);
    end

    // Final result from the last step's accumulator, with sign restoration.
    always_comb begin
        prod    = neg_res_q ? (2*WIDTH)'((~step_acc) + (2*WIDTH)'(1)) : step_acc;
        quo_fix = md_abs(step_acc[WIDTH-1:0], neg_res_q);
        rem_fix = md_abs(step_acc[2*WIDTH-1:WIDTH], neg_rem_q);
        if (mode_q == STEP_MUL) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else begin
            // Divide by zero: remainder already equals a as issued; quotient forced.
            res_hi = rem_fix;
            res_lo = div0_q ? '1 : quo_fix;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        mode_d    = mode_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    unique case (op)
                        MD_MULT, MD_MULTU: begin
                            state_d   = ST_RUN;
                            busy_d    = 1'b1;
                            cnt_d     = '0;
                            mode_d    = STEP_MUL;
                            acc_d     = {{WIDTH{1'b0}}, mag_b};
                            opnd_d    = mag_a;
                            neg_res_d = sgn_a ^ sgn_b;
                            neg_rem_d = 1'b0;
                            div0_d    = 1'b0;
                        end
                        MD_DIV, MD_DIVU: begin
                            state_d   = ST_RUN;
                            busy_d    = 1'b1;
                            cnt_d     = '0;
                            mode_d    = STEP_DIV;
                            acc_d     = {{WIDTH{1'b0}}, mag_a};
                            opnd_d    = mag_b;
                            neg_res_d = sgn_a ^ sgn_b;
                            neg_rem_d = sgn_a;
                            div0_d    = (bus.b == '0);
                        end
                        MD_MTHI: hi_d = bus.a;
                        MD_MTLO: lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                busy_d = 1'b1;
                acc_d  = step_acc;
                cnt_d  = cnt_q + MD_CNT_W'(1);
                if (cnt_q == MD_LAST_STEP) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            mode_q    <= STEP_MUL;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            mode_q    <= mode_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// Directed self-checking bench for muldiv.
module tb_muldiv;
    import muldiv_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    muldiv_if bus ();

    muldiv #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one issue for a single rising edge; returns 1 time unit after it.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Count sampled cycles with busy high; bounded so a stuck busy cannot hang.
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", bus.done); end
        tests++; if (bus.hi !== 32'h0) begin fails++; $display("FAIL reset_hi: got %h want 00000000", bus.hi); end
        tests++; if (bus.lo !== 32'h0) begin fails++; $display("FAIL reset_lo: got %h want 00000000", bus.lo); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_multu_max();
        int cyc;
        issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle(cyc);
        tests++; if (cyc !== 32) begin fails++; $display("FAIL multu_busy_cycles: got %0d want 32", cyc); end
        tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL multu_done: got %b want 1", bus.done); end
        tests++; if (bus.hi !== 32'hFFFFFFFE) begin fails++; $display("FAIL multu_hi: got %h want FFFFFFFE", bus.hi); end
        tests++; if (bus.lo !== 32'h00000001) begin fails++; $display("FAIL multu_lo: got %h want 00000001", bus.lo); end
        @(posedge clk); #1;
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL multu_done_pulse: got %b want 0", bus.done); end
    endtask

    task automatic test_mult_signed();
        int cyc;
        issue(MD_MULT, 32'hFFFFFFFD, 32'd7);
        repeat (15) @(posedge clk);
        #1;
        tests++; if (bus.hi !== 32'hFFFFFFFE) begin fails++; $display("FAIL mult_hold_hi: got %h want FFFFFFFE", bus.hi); end
        tests++; if (bus.lo !== 32'h00000001) begin fails++; $display("FAIL mult_hold_lo: got %h want 00000001", bus.lo); end
        wait_idle(cyc);
        tests++; if (cyc !== 17) begin fails++; $display("FAIL mult_busy_rest: got %0d want 17", cyc); end
        tests++; if (bus.hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL mult_hi: got %h want FFFFFFFF", bus.hi); end
        tests++; if (bus.lo !== 32'hFFFFFFEB) begin fails++; $display("FAIL mult_lo: got %h want FFFFFFEB", bus.lo); end
    endtask

    task automatic test_divide();
        int cyc;
        logic [2:0]  ops  [3] = '{MD_DIV, MD_DIVU, MD_DIV};
        logic [31:0] va   [3] = '{32'hFFFFFFF9, 32'd7, 32'h80000000};
        logic [31:0] vb   [3] = '{32'd2, 32'd2, 32'hFFFFFFFF};
        logic [31:0] elo  [3] = '{32'hFFFFFFFD, 32'd3, 32'h80000000};
        logic [31:0] ehi  [3] = '{32'hFFFFFFFF, 32'd1, 32'h0};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], va[i], vb[i]);
            wait_idle(cyc);
            tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL div%0d_done: got %b want 1", i, bus.done); end
            tests++; if (bus.lo !== elo[i]) begin fails++; $display("FAIL div%0d_lo: got %h want %h", i, bus.lo, elo[i]); end
            tests++; if (bus.hi !== ehi[i]) begin fails++; $display("FAIL div%0d_hi: got %h want %h", i, bus.hi, ehi[i]); end
        end
    endtask

    task automatic test_div_zero();
        int cyc;
        issue(MD_DIVU, 32'h00001234, 32'h0);
        wait_idle(cyc);
        tests++; if (cyc !== 32) begin fails++; $display("FAIL div0_busy_cycles: got %0d want 32", cyc); end
        tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL div0_done: got %b want 1", bus.done); end
        tests++; if (bus.lo !== 32'hFFFFFFFF) begin fails++; $display("FAIL div0_lo: got %h want FFFFFFFF", bus.lo); end
        tests++; if (bus.hi !== 32'h00001234) begin fails++; $display("FAIL div0_hi: got %h want 00001234", bus.hi); end
        issue(MD_DIV, 32'hFFFFFF00, 32'h0);
        wait_idle(cyc);
        tests++; if (bus.lo !== 32'hFFFFFFFF) begin fails++; $display("FAIL sdiv0_lo: got %h want FFFFFFFF", bus.lo); end
        tests++; if (bus.hi !== 32'hFFFFFF00) begin fails++; $display("FAIL sdiv0_hi: got %h want FFFFFF00", bus.hi); end
    endtask

    task automatic test_mthi_idle();
        issue(MD_MTHI, 32'hDEADBEEF, 32'h0);
        tests++; if (bus.hi !== 32'hDEADBEEF) begin fails++; $display("FAIL mthi_hi: got %h want DEADBEEF", bus.hi); end
        tests++; if (bus.lo !== 32'hFFFFFFFF) begin fails++; $display("FAIL mthi_lo_keep: got %h want FFFFFFFF", bus.lo); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL mthi_busy: got %b want 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL mthi_done: got %b want 0", bus.done); end
        issue(MD_MTLO, 32'h0BADF00D, 32'h0);
        tests++; if (bus.lo !== 32'h0BADF00D) begin fails++; $display("FAIL mtlo_lo: got %h want 0BADF00D", bus.lo); end
        issue(MD_NOP6, 32'h11111111, 32'h22222222);
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL nop_busy: got %b want 0", bus.busy); end
        tests++; if (bus.hi !== 32'hDEADBEEF) begin fails++; $display("FAIL nop_hi: got %h want DEADBEEF", bus.hi); end
        tests++; if (bus.lo !== 32'h0BADF00D) begin fails++; $display("FAIL nop_lo: got %h want 0BADF00D", bus.lo); end
    endtask

    task automatic test_busy_ignore();
        int cyc;
        issue(MD_DIVU, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        issue(MD_MTLO, 32'h00000055, 32'h0);
        tests++; if (bus.lo !== 32'h0BADF00D) begin fails++; $display("FAIL busy_mtlo_lo: got %h want 0BADF00D", bus.lo); end
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL busy_mtlo_busy: got %b want 1", bus.busy); end
        wait_idle(cyc);
        tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL busy_final_done: got %b want 1", bus.done); end
        tests++; if (bus.lo !== 32'd14) begin fails++; $display("FAIL busy_final_lo: got %h want 0000000e", bus.lo); end
        tests++; if (bus.hi !== 32'd2) begin fails++; $display("FAIL busy_final_hi: got %h want 00000002", bus.hi); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        issue(MD_DIVU, 32'd7, 32'd2);
        wait_idle(cyc);
        tests++; if (bus.lo !== 32'd3 || bus.hi !== 32'd1) begin fails++; $display("FAIL b2b_first: got hi %h lo %h want 00000001 00000003", bus.hi, bus.lo); end
        // Next issue lands on the edge that ends the done cycle.
        issue(MD_MULT, 32'hFFFFFFFD, 32'd7);
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL b2b_accept: got %b want 1", bus.busy); end
        wait_idle(cyc);
        tests++; if (cyc !== 32) begin fails++; $display("FAIL b2b_busy_cycles: got %0d want 32", cyc); end
        tests++; if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFEB) begin fails++; $display("FAIL b2b_second: got hi %h lo %h want FFFFFFFF FFFFFFEB", bus.hi, bus.lo); end
    endtask

    task automatic test_reset_mid_run();
        int  cyc;
        bit  saw_done;
        issue(MD_MULTU, 32'h0000FFFF, 32'h0000FFFF);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rstrun_busy: got %b want 0", bus.busy); end
        tests++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin fails++; $display("FAIL rstrun_hilo: got hi %h lo %h want 0 0", bus.hi, bus.lo); end
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
        end
        tests++; if (saw_done !== 1'b0) begin fails++; $display("FAIL rstrun_no_done: got %b want 0", saw_done); end
        issue(MD_MULTU, 32'd6, 32'd7);
        wait_idle(cyc);
        tests++; if (bus.lo !== 32'd42 || bus.hi !== 32'd0) begin fails++; $display("FAIL rstrun_fresh: got hi %h lo %h want 00000000 0000002a", bus.hi, bus.lo); end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = 32'h0;
        bus.b     = 32'h0;
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_divide();
        test_div_zero();
        test_mthi_idle();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
